// File: rtl/core_wb_pkg.sv
// Shared definitions for the core writeback stage: FSM state encoding and
// the source-select codes the arbiter hands to the writeback FSM.
package core_wb_pkg;

  localparam int REG_AW = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2
  } wb_state_e;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_LD   = 2'd1,
    SRC_EX   = 2'd2,
    SRC_IN   = 2'd3
  } wb_src_e;

endpackage

// File: rtl/core_wb_arb.sv
// Three-input fixed-priority grant (LD > EX > IN), active only while the
// writeback FSM offers an accept slot. Purely combinational.
module core_wb_arb
  import core_wb_pkg::*;
(
  input  logic    en,
  input  logic    ld_req,
  input  logic    ex_req,
  input  logic    in_req,
  output logic    ld_gnt,
  output logic    ex_gnt,
  output logic    in_gnt,
  output wb_src_e src
);

  always_comb begin
    // NOTE: every output gets a default before the if-chain, so no path leaves one unassigned and no latch is inferred.
    ld_gnt = 1'b0;
    ex_gnt = 1'b0;
    in_gnt = 1'b0;
    src    = SRC_NONE;
    if (en) begin
      if (ld_req) begin
        ld_gnt = 1'b1;
        src    = SRC_LD;
      end else if (ex_req) begin
        ex_gnt = 1'b1;
        src    = SRC_EX;
      end else if (in_req) begin
        in_gnt = 1'b1;
        src    = SRC_IN;
      end
    end
  end

endmodule

// File: rtl/core_wb.sv
// Writeback stage: accepts one result from LD/EX/IN every two cycles and
// drives the register-file write port with a one-cycle strobe plus one hold cycle.
module core_wb
  import core_wb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              EX_VALID,
  output logic              EX_READY,
  input  logic              EX_FP,
  input  logic [REG_AW-1:0] EX_RD,
  input  logic [XLEN-1:0]   EX_DATA,
  input  logic              LD_VALID,
  output logic              LD_READY,
  input  logic              LD_FP,
  input  logic [REG_AW-1:0] LD_RD,
  input  logic [XLEN-1:0]   LD_DATA,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [REG_AW-1:0] IN_RD,
  input  logic [7:0]        IN_DATA,
  output logic              WE,
  output logic [REG_AW-1:0] WADDR,
  output logic [REG_AW-1:0] FWADDR,
  output logic [XLEN-1:0]   WDATA,
  output logic              INE,
  output logic [7:0]        INDATA
);

  wb_state_e state;
  wb_src_e   src;
  logic      accept_slot;

  // Reset gates the slot so READY stays low while RST_N is held.
  assign accept_slot = RST_N && (state != ISSUE);

  core_wb_arb u_arb (
    .en     (accept_slot),
    .ld_req (LD_VALID),
    .ex_req (EX_VALID),
    .in_req (IN_VALID),
    .ld_gnt (LD_READY),
    .ex_gnt (EX_READY),
    .in_gnt (IN_READY),
    .src    (src)
  );

  logic              sel_in;
  logic              sel_fp;
  logic [REG_AW-1:0] sel_rd;
  logic [XLEN-1:0]   sel_data;
  logic [7:0]        sel_byte;
  logic              rd_nz;

  always_comb begin
    sel_in   = 1'b0;
    sel_fp   = 1'b0;
    sel_rd   = '0;
    sel_data = '0;
    sel_byte = '0;
    unique case (src)
      SRC_LD: begin
        sel_fp   = LD_FP;
        sel_rd   = LD_RD;
        sel_data = LD_DATA;
      end
      SRC_EX: begin
        sel_fp   = EX_FP;
        sel_rd   = EX_RD;
        sel_data = EX_DATA;
      end
      SRC_IN: begin
        sel_in   = 1'b1;
        sel_rd   = IN_RD;
        sel_byte = IN_DATA;
      end
      default: ;
    endcase
  end

  // Destination 0 (integer x0 or float f0) is accepted but never written.
  assign rd_nz = |sel_rd;

  always_ff @(posedge CLK or negedge RST_N) begin
    // NOTE: sequential state uses non-blocking assignments; these are control/output flops (no storage array), so all take the async reset.
    if (!RST_N) begin
      state  <= IDLE;
      WE     <= 1'b0;
      INE    <= 1'b0;
      WADDR  <= '0;
      FWADDR <= '0;
      WDATA  <= '0;
      INDATA <= '0;
    end else begin
      unique case (state)
        ISSUE: begin
          state <= HOLD;
          WE    <= 1'b0;
          INE   <= 1'b0;
        end
        default: begin
          if (src != SRC_NONE) begin
            state  <= ISSUE;
            WE     <= !sel_in && rd_nz;
            INE    <= sel_in && rd_nz;
            WADDR  <= sel_fp ? '0 : sel_rd;
            FWADDR <= sel_fp ? sel_rd : '0;
            WDATA  <= sel_in ? '0 : sel_data;
            INDATA <= sel_in ? sel_byte : '0;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_core_wb.sv
// Scoreboard bench for core_wb: producers feed per-channel item queues, a
// priority/slot model predicts grants and pushes expected writes, a monitor checks them.
module tb_core_wb;

  localparam int XLEN = 32;

  logic            CLK = 1'b0;
  logic            RST_N;
  logic            EX_VALID, EX_READY, EX_FP;
  logic [4:0]      EX_RD;
  logic [XLEN-1:0] EX_DATA;
  logic            LD_VALID, LD_READY, LD_FP;
  logic [4:0]      LD_RD;
  logic [XLEN-1:0] LD_DATA;
  logic            IN_VALID, IN_READY;
  logic [4:0]      IN_RD;
  logic [7:0]      IN_DATA;
  logic            WE, INE;
  logic [4:0]      WADDR, FWADDR;
  logic [XLEN-1:0] WDATA;
  logic [7:0]      INDATA;

  core_wb #(.XLEN(XLEN)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .EX_VALID(EX_VALID), .EX_READY(EX_READY), .EX_FP(EX_FP), .EX_RD(EX_RD), .EX_DATA(EX_DATA),
    .LD_VALID(LD_VALID), .LD_READY(LD_READY), .LD_FP(LD_FP), .LD_RD(LD_RD), .LD_DATA(LD_DATA),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_RD(IN_RD), .IN_DATA(IN_DATA),
    .WE(WE), .WADDR(WADDR), .FWADDR(FWADDR), .WDATA(WDATA), .INE(INE), .INDATA(INDATA)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        fp;
    logic [4:0]  rd;
    logic [31:0] data;
  } item_t;

  typedef struct {
    int unsigned cyc;
    logic        we;
    logic        ine;
    logic [4:0]  waddr;
    logic [4:0]  fwaddr;
    logic [31:0] wdata;
    logic [7:0]  indata;
  } wr_t;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned cyc   = 0;

  item_t ld_q[$], ex_q[$], in_q[$];
  wr_t   sb[$];
  bit    busy = 0;
  bit    gaps = 0;
  bit    hs_ld = 0, hs_ex = 0, hs_in = 0;
  bit    hold_pend = 0;
  int unsigned hold_cyc = 0;
  wr_t   hold_exp;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, got, exp);
    end
  endtask

  function automatic logic [63:0] pack_out();
    return 64'({WE, INE, WADDR, FWADDR, WDATA, INDATA});
  endfunction

  function automatic logic [63:0] pack_wr(input wr_t e);
    return 64'({e.we, e.ine, e.waddr, e.fwaddr, e.wdata, e.indata});
  endfunction

  // Expected register-file write for an item from channel ch (0=LD, 1=EX, 2=IN).
  function automatic wr_t expect_write(input int ch, input item_t it, input int unsigned at);
    wr_t e;
    e.cyc = at; e.we = 0; e.ine = 0; e.waddr = 0; e.fwaddr = 0; e.wdata = 0; e.indata = 0;
    if (ch == 2) begin
      e.waddr  = it.rd;
      e.indata = it.data[7:0];
      e.ine    = (it.rd != 0);
    end else begin
      if (it.fp) e.fwaddr = it.rd;
      else       e.waddr  = it.rd;
      e.wdata = it.data;
      e.we    = (it.rd != 0);
    end
    return e;
  endfunction

  // Producers: hold VALID/payload until handshake, junk payload while idle.
  task automatic present();
    if (hs_ld) begin LD_VALID = 0; ld_q.delete(0); end
    if (hs_ex) begin EX_VALID = 0; ex_q.delete(0); end
    if (hs_in) begin IN_VALID = 0; in_q.delete(0); end
    if (!LD_VALID) begin
      if (ld_q.size() != 0 && (!gaps || $urandom_range(0, 3) != 0)) begin
        LD_VALID = 1; LD_FP = ld_q[0].fp; LD_RD = ld_q[0].rd; LD_DATA = ld_q[0].data;
      end else begin
        LD_FP = 1'($urandom_range(0, 1)); LD_RD = 5'($urandom_range(0, 31)); LD_DATA = $urandom;
      end
    end
    if (!EX_VALID) begin
      if (ex_q.size() != 0 && (!gaps || $urandom_range(0, 3) != 0)) begin
        EX_VALID = 1; EX_FP = ex_q[0].fp; EX_RD = ex_q[0].rd; EX_DATA = ex_q[0].data;
      end else begin
        EX_FP = 1'($urandom_range(0, 1)); EX_RD = 5'($urandom_range(0, 31)); EX_DATA = $urandom;
      end
    end
    if (!IN_VALID) begin
      if (in_q.size() != 0 && (!gaps || $urandom_range(0, 3) != 0)) begin
        IN_VALID = 1; IN_RD = in_q[0].rd; IN_DATA = in_q[0].data[7:0];
      end else begin
        IN_RD = 5'($urandom_range(0, 31)); IN_DATA = 8'($urandom_range(0, 255));
      end
    end
  endtask

  // Model: after every acceptance one cycle offers no slot; otherwise LD > EX > IN.
  task automatic sample();
    int g;
    logic [2:0] exp_rdy;
    g = -1;
    if (!busy && RST_N) begin
      if (LD_VALID)      g = 0;
      else if (EX_VALID) g = 1;
      else if (IN_VALID) g = 2;
    end
    exp_rdy = {g == 0, g == 1, g == 2};
    check("ready{ld,ex,in}", 64'({LD_READY, EX_READY, IN_READY}), 64'(exp_rdy));
    busy = 0;
    if (g == 0) begin sb.push_back(expect_write(0, ld_q[0], cyc + 1)); busy = 1; end
    if (g == 1) begin sb.push_back(expect_write(1, ex_q[0], cyc + 1)); busy = 1; end
    if (g == 2) begin sb.push_back(expect_write(2, in_q[0], cyc + 1)); busy = 1; end
    hs_ld = LD_VALID && LD_READY;
    hs_ex = EX_VALID && EX_READY;
    hs_in = IN_VALID && IN_READY;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
    present();
    @(negedge CLK);
    sample();
  endtask

  function automatic bit idle_all();
    return ld_q.size() == 0 && ex_q.size() == 0 && in_q.size() == 0 &&
           !LD_VALID && !EX_VALID && !IN_VALID && sb.size() == 0 && !hold_pend && !busy;
  endfunction

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (!idle_all() && n < budget) begin
      step();
      n++;
    end
    check("drain_done", 64'(idle_all()), 64'd1);
  endtask

  function automatic item_t mk(input logic fp, input logic [4:0] rd, input logic [31:0] d);
    item_t it;
    it.fp = fp; it.rd = rd; it.data = d;
    return it;
  endfunction

  // Monitor: ISSUE cycle shows the strobe, HOLD keeps address/data with strobes low.
  always @(negedge CLK) begin
    wr_t e;
    bit  seen;
    seen = 0;
    if (!RST_N) begin
      hold_pend = 0;
    end else begin
      if (hold_pend && hold_cyc == cyc) begin
        check("hold_outputs", pack_out(), pack_wr(hold_exp));
        hold_pend = 0;
        seen = 1;
      end
      while (sb.size() != 0 && sb[0].cyc < cyc) begin
        e = sb.pop_front();
        check("issue_missed", 64'(cyc), 64'(e.cyc));
      end
      if (sb.size() != 0 && sb[0].cyc == cyc) begin
        e = sb.pop_front();
        check("issue_outputs", pack_out(), pack_wr(e));
        hold_exp     = e;
        hold_exp.we  = 0;
        hold_exp.ine = 0;
        hold_cyc     = cyc + 1;
        hold_pend    = 1;
        seen = 1;
      end
      if (!seen) check("no_strobe_outside_issue", 64'({WE, INE}), 64'd0);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RST_N = 0;
    LD_VALID = 0; LD_FP = 0; LD_RD = 0; LD_DATA = 0;
    EX_VALID = 0; EX_FP = 0; EX_RD = 0; EX_DATA = 0;
    IN_VALID = 0; IN_RD = 0; IN_DATA = 0;
    #2;
    LD_VALID = 1; EX_VALID = 1; IN_VALID = 1;
    #1;
    check("reset_outputs", pack_out(), 64'd0);
    check("reset_ready", 64'({LD_READY, EX_READY, IN_READY}), 64'd0);
    LD_VALID = 0; EX_VALID = 0; IN_VALID = 0;
    repeat (3) @(negedge CLK);
    RST_N = 1;

    // Integer EX write.
    ex_q.push_back(mk(1'b0, 5'd5, 32'h1234_5678));
    drain(20);
    // LD (float) and EX (int) together: LD first, EX in the HOLD slot.
    ld_q.push_back(mk(1'b1, 5'd3, 32'hDEAD_BEEF));
    ex_q.push_back(mk(1'b0, 5'd7, 32'h0BAD_F00D));
    drain(20);
    // Serial input byte.
    in_q.push_back(mk(1'b0, 5'd10, 32'h0000_0041));
    drain(20);
    // Destination zero, integer and float.
    ex_q.push_back(mk(1'b0, 5'd0, 32'hFFFF_FFFF));
    ld_q.push_back(mk(1'b1, 5'd0, 32'h5555_AAAA));
    in_q.push_back(mk(1'b0, 5'd0, 32'h0000_00C3));
    drain(30);
    // Four back-to-back EX items with VALID held high.
    for (int i = 0; i < 4; i++) ex_q.push_back(mk(1'(i & 1), 5'(i + 20), 32'hA000_0000 + 32'(i)));
    drain(30);

    // Asynchronous reset during HOLD.
    ex_q.push_back(mk(1'b0, 5'd9, 32'hCAFE_F00D));
    for (int i = 0; i < 20 && sb.size() == 0; i++) step();
    step();
    @(posedge CLK);
    #2;
    RST_N = 0;
    #1;
    check("reset_in_hold_outputs", pack_out(), 64'd0);
    check("reset_in_hold_ready", 64'({LD_READY, EX_READY, IN_READY}), 64'd0);
    sb.delete(); ld_q.delete(); ex_q.delete(); in_q.delete();
    busy = 0; hs_ld = 0; hs_ex = 0; hs_in = 0;
    LD_VALID = 0; EX_VALID = 0; IN_VALID = 0;
    repeat (2) @(negedge CLK);
    RST_N = 1;
    ex_q.push_back(mk(1'b0, 5'd12, 32'h0000_1212));
    drain(20);

    // Randomized traffic with random producer gaps.
    gaps = 1;
    for (int i = 0; i < 200; i++) begin
      item_t it;
      int ch;
      ch = $urandom_range(0, 2);
      it = mk(1'($urandom_range(0, 1)),
              ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
              $urandom);
      if (ch == 0) ld_q.push_back(it);
      else if (ch == 1) ex_q.push_back(it);
      else in_q.push_back(it);
    end
    drain(4000);
    repeat (2) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
